dispatch_buffer: RTL and testbench

- N-wide successor of the 2-wide dispatch stage. Registers a renamed bundle from rename/decode and compacts its valid lanes to the oldest slots.
- Dispatches an in-order prefix of held instructions to ROB and issue queues, limited by ROB, store-queue and issue-queue free counts.
- Holds undispatched instructions across cycles and backpressures rename.
- Assigns ROB indices and store-queue numbering per dispatched instruction.

---
 rtl/dispatch_buffer.sv | 130 +++++++++++++
 tb/tb_dispatch_buffer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/dispatch_buffer.sv
// dispatch_buffer: holds a compacted rename bundle and dispatches an in-order, credit-limited prefix to ROB/IQ/SQ
module dispatch_buffer #(
  parameter int WIDTH     = 2,
  parameter int PAYLOAD_W = 128,
  parameter int ROB_AW    = 4,
  parameter int SQ_AW     = 4,
  parameter int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           in_valid,
  input  logic [WIDTH*PAYLOAD_W-1:0] in_payload,
  input  logic [WIDTH-1:0]           in_is_store,
  input  logic [WIDTH-1:0]           in_exc,
  output logic                       in_ready,
  input  logic [ROB_AW-1:0]          rob_tail,
  input  logic [ROB_AW:0]            rob_free,
  input  logic [SQ_AW-1:0]           sq_head,
  input  logic [SQ_AW-1:0]           sq_tail,
  input  logic [SQ_AW:0]             sq_free,
  input  logic [CNT_W-1:0]           iq_free,
  output logic [WIDTH-1:0]           rob_valid,
  output logic [WIDTH-1:0]           issue_valid,
  output logic [WIDTH-1:0]           out_exc,
  output logic [WIDTH*PAYLOAD_W-1:0] out_payload,
  output logic [WIDTH*ROB_AW-1:0]    out_rob_idx,
  output logic [WIDTH*SQ_AW-1:0]     out_store_num,
  output logic [WIDTH*SQ_AW-1:0]     out_pre_store,
  output logic [WIDTH-1:0]           out_pre_store_ready,
  output logic [CNT_W-1:0]           rob_alloc,
  output logic [CNT_W-1:0]           sq_alloc
);
  logic [PAYLOAD_W-1:0] pay_q [WIDTH];
  logic [PAYLOAD_W-1:0] pay_d [WIDTH];
  logic [WIDTH-1:0]     st_q, st_d, exc_q, exc_d;
  logic [CNT_W-1:0]     hold_cnt, hold_d;
  logic                 accept;
  int                   k;

  assign in_ready = !flush && (k == int'(hold_cnt));
  assign accept   = |in_valid && in_ready;

  // longest held prefix that fits ROB, issue-queue and store-queue credit; exceptions only need a ROB entry
  always_comb begin
    int  ni, ns;
    logic blk;
    k   = 0;
    ni  = 0;
    ns  = 0;
    blk = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      ni = ni + (exc_q[i] ? 0 : 1);
      ns = ns + ((st_q[i] && !exc_q[i]) ? 1 : 0);
      if (!blk && i < int'(hold_cnt) && i < int'(rob_free) && ni <= int'(iq_free) && ns <= int'(sq_free)) k = i + 1;
      else blk = 1'b1;
    end
  end

  // per-slot dispatch strobes and ROB/store-queue numbering
  always_comb begin
    int s;
    s                   = 0;
    rob_valid           = '0;
    issue_valid         = '0;
    out_exc             = exc_q;
    out_payload         = '0;
    out_rob_idx         = '0;
    out_store_num       = '0;
    out_pre_store       = '0;
    out_pre_store_ready = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rob_valid[i]                          = !flush && i < k;
      issue_valid[i]                        = !flush && i < k && !exc_q[i];
      out_payload[i*PAYLOAD_W +: PAYLOAD_W] = pay_q[i];
      out_rob_idx[i*ROB_AW +: ROB_AW]       = rob_tail + ROB_AW'(i);
      out_store_num[i*SQ_AW +: SQ_AW]       = sq_tail + SQ_AW'(s);
      out_pre_store[i*SQ_AW +: SQ_AW]       = sq_tail + SQ_AW'(s) - SQ_AW'(1);
      out_pre_store_ready[i]                = (sq_head == sq_tail) && s == 0;
      if (i < k && st_q[i] && !exc_q[i]) s = s + 1;
    end
    rob_alloc = flush ? '0 : CNT_W'(k);
    sq_alloc  = flush ? '0 : CNT_W'(s);
  end

  // next slot contents: compacted load of a new bundle, else shift out the dispatched prefix
  always_comb begin
    int p;
    p      = 0;
    pay_d  = pay_q;
    st_d   = st_q;
    exc_d  = exc_q;
    hold_d = hold_cnt - CNT_W'(k);
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++)
        if (j == i + k) begin
          pay_d[i] = pay_q[j];
          st_d[i]  = st_q[j];
          exc_d[i] = exc_q[j];
        end
    if (accept) begin
      for (int i = 0; i < WIDTH; i++)
        if (in_valid[i]) begin
          for (int d = 0; d < WIDTH; d++)
            if (d == p) begin
              pay_d[d] = in_payload[i*PAYLOAD_W +: PAYLOAD_W];
              st_d[d]  = in_is_store[i];
              exc_d[d] = in_exc[i];
            end
          p = p + 1;
        end
      hold_d = CNT_W'(p);
    end
    if (flush) hold_d = '0;
  end

  // slot registers; only the count and flags need clearing on reset
  always_ff @(posedge clk) begin
    pay_q <= pay_d;
    if (reset) begin
      hold_cnt <= '0;
      st_q     <= '0;
      exc_q    <= '0;
    end else begin
      hold_cnt <= hold_d;
      st_q     <= st_d;
      exc_q    <= exc_d;
    end
  end
endmodule

// File: tb/tb_dispatch_buffer.sv
// tb_dispatch_buffer: table-driven directed checks of dispatch_buffer at WIDTH=4
module tb_dispatch_buffer;
  localparam int W = 4;
  localparam int PW = 128;

  logic            clk = 1'b0;
  logic            reset, flush;
  logic [W-1:0]    in_valid, in_is_store, in_exc;
  logic [W*PW-1:0] in_payload;
  logic            in_ready;
  logic [3:0]      rob_tail, sq_head, sq_tail;
  logic [4:0]      rob_free, sq_free;
  logic [2:0]      iq_free;
  logic [W-1:0]    rob_valid, issue_valid, out_exc, out_pre_store_ready;
  logic [W*PW-1:0] out_payload;
  logic [W*4-1:0]  out_rob_idx, out_store_num, out_pre_store;
  logic [2:0]      rob_alloc, sq_alloc;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  dispatch_buffer #(.WIDTH(W), .PAYLOAD_W(PW), .ROB_AW(4), .SQ_AW(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_payload(in_payload), .in_is_store(in_is_store), .in_exc(in_exc),
    .in_ready(in_ready),
    .rob_tail(rob_tail), .rob_free(rob_free), .sq_head(sq_head), .sq_tail(sq_tail),
    .sq_free(sq_free), .iq_free(iq_free),
    .rob_valid(rob_valid), .issue_valid(issue_valid), .out_exc(out_exc), .out_payload(out_payload),
    .out_rob_idx(out_rob_idx), .out_store_num(out_store_num), .out_pre_store(out_pre_store),
    .out_pre_store_ready(out_pre_store_ready), .rob_alloc(rob_alloc), .sq_alloc(sq_alloc)
  );

  typedef struct {
    logic [3:0]  v, st, ex;
    logic        fl;
    logic [3:0]  rt;
    logic [4:0]  rf;
    logic [3:0]  sh, stl;
    logic [4:0]  sf;
    logic [2:0]  iq;
    logic [3:0]  rv, iv;
    logic [2:0]  ra, sa;
    logic        rdy;
    logic [15:0] ridx, snum, pst;
    logic [3:0]  psr;
    logic [7:0]  p0;
  } vec_t;

  vec_t vt [16];

  task automatic check(input string nm, input int r, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s step %0d: got %h expected %h", nm, r, act, exp);
  endtask

  task automatic drive(input logic [3:0] v, st, ex, input logic fl, input logic [3:0] rt,
                       input logic [4:0] rf, input logic [3:0] sh, stl, input logic [4:0] sf,
                       input logic [2:0] iq);
    in_valid = v; in_is_store = st; in_exc = ex; flush = fl; rob_tail = rt;
    rob_free = rf; sq_head = sh; sq_tail = stl; sq_free = sf; iq_free = iq;
  endtask

  initial begin
    // held slot0 shows lane payloads A0..A3 after compaction
    //            v       st      ex      fl  rt  rf  sh  stl sf  iq   rv      iv      ra sa rdy ridx     snum     pst      psr     p0
    vt[0]  = '{4'b0011,4'b0000,4'b0000,0, 14, 16, 0,  0,  16, 4,  4'b0000,4'b0000,0, 0, 1, 16'h10FE,16'h0000,16'hFFFF,4'b1111,8'h00};
    vt[1]  = '{4'b0010,4'b0000,4'b0000,0, 14, 16, 0,  0,  16, 4,  4'b0011,4'b0011,2, 0, 1, 16'h10FE,16'h0000,16'hFFFF,4'b1111,8'hA0};
    vt[2]  = '{4'b1111,4'b1010,4'b0000,0, 3,  16, 15, 15, 16, 4,  4'b0001,4'b0001,1, 0, 1, 16'h6543,16'hFFFF,16'hEEEE,4'b1111,8'hA1};
    vt[3]  = '{4'b0000,4'b0000,4'b0000,0, 3,  16, 15, 15, 16, 4,  4'b1111,4'b1111,4, 2, 1, 16'h6543,16'h00FF,16'hFFEE,4'b0011,8'hA0};
    vt[4]  = '{4'b0111,4'b0000,4'b0000,0, 0,  16, 0,  0,  16, 4,  4'b0000,4'b0000,0, 0, 1, 16'h3210,16'h0000,16'hFFFF,4'b1111,8'h00};
    vt[5]  = '{4'b0000,4'b0000,4'b0000,0, 0,  1,  0,  0,  16, 4,  4'b0001,4'b0001,1, 0, 0, 16'h3210,16'h0000,16'hFFFF,4'b1111,8'hA0};
    vt[6]  = '{4'b0011,4'b0000,4'b0001,0, 0,  4,  0,  0,  16, 4,  4'b0011,4'b0011,2, 0, 1, 16'h3210,16'h0000,16'hFFFF,4'b1111,8'hA1};
    vt[7]  = '{4'b0000,4'b0000,4'b0000,0, 0,  16, 0,  0,  16, 1,  4'b0011,4'b0010,2, 0, 1, 16'h3210,16'h0000,16'hFFFF,4'b1111,8'hA0};
    vt[8]  = '{4'b0111,4'b0001,4'b0000,0, 0,  16, 0,  0,  16, 4,  4'b0000,4'b0000,0, 0, 1, 16'h3210,16'h0000,16'hFFFF,4'b1111,8'h00};
    vt[9]  = '{4'b0000,4'b0000,4'b0000,0, 0,  16, 0,  0,  0,  4,  4'b0000,4'b0000,0, 0, 0, 16'h3210,16'h0000,16'hFFFF,4'b1111,8'h00};
    vt[10] = '{4'b0011,4'b0000,4'b0000,1, 0,  16, 0,  0,  0,  4,  4'b0000,4'b0000,0, 0, 0, 16'h3210,16'h0000,16'hFFFF,4'b1111,8'h00};
    vt[11] = '{4'b0000,4'b0000,4'b0000,0, 0,  16, 0,  0,  16, 4,  4'b0000,4'b0000,0, 0, 1, 16'h3210,16'h0000,16'hFFFF,4'b1111,8'h00};
    vt[12] = '{4'b0111,4'b0000,4'b0000,0, 0,  16, 0,  0,  16, 4,  4'b0000,4'b0000,0, 0, 1, 16'h3210,16'h0000,16'hFFFF,4'b1111,8'h00};
    vt[13] = '{4'b0000,4'b0000,4'b0000,0, 0,  16, 0,  0,  16, 2,  4'b0011,4'b0011,2, 0, 0, 16'h3210,16'h0000,16'hFFFF,4'b1111,8'hA0};
    vt[14] = '{4'b0000,4'b0000,4'b0000,0, 0,  16, 0,  0,  16, 4,  4'b0001,4'b0001,1, 0, 1, 16'h3210,16'h0000,16'hFFFF,4'b1111,8'hA2};
    vt[15] = '{4'b0000,4'b0000,4'b0000,0, 0,  16, 2,  5,  16, 4,  4'b0000,4'b0000,0, 0, 1, 16'h3210,16'h5555,16'h4444,4'b0000,8'h00};

    in_payload = {128'hA3, 128'hA2, 128'hA1, 128'hA0};
    reset = 1'b1;
    drive(4'b0, 4'b0, 4'b0, 1'b0, 4'd0, 5'd16, 4'd0, 4'd0, 5'd16, 3'd4);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_rob_valid", -1, 32'(rob_valid), 32'h0);
    check("reset_issue_valid", -1, 32'(issue_valid), 32'h0);
    check("reset_rob_alloc", -1, 32'(rob_alloc), 32'h0);
    check("reset_sq_alloc", -1, 32'(sq_alloc), 32'h0);
    check("reset_in_ready", -1, 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;

    for (int r = 0; r < 16; r++) begin
      drive(vt[r].v, vt[r].st, vt[r].ex, vt[r].fl, vt[r].rt, vt[r].rf, vt[r].sh, vt[r].stl, vt[r].sf, vt[r].iq);
      @(negedge clk);
      check("rob_valid", r, 32'(rob_valid), 32'(vt[r].rv));
      check("issue_valid", r, 32'(issue_valid), 32'(vt[r].iv));
      check("rob_alloc", r, 32'(rob_alloc), 32'(vt[r].ra));
      check("sq_alloc", r, 32'(sq_alloc), 32'(vt[r].sa));
      check("in_ready", r, 32'(in_ready), 32'(vt[r].rdy));
      check("rob_idx", r, 32'(out_rob_idx), 32'(vt[r].ridx));
      check("store_num", r, 32'(out_store_num), 32'(vt[r].snum));
      check("pre_store", r, 32'(out_pre_store), 32'(vt[r].pst));
      check("pre_store_ready", r, 32'(out_pre_store_ready), 32'(vt[r].psr));
      if (vt[r].rv[0]) check("slot0_payload", r, 32'(out_payload[7:0]), 32'(vt[r].p0));
      @(posedge clk);
      #1;
    end

    drive(4'b0011, 4'b0, 4'b0, 1'b0, 4'd0, 5'd16, 4'd0, 4'd0, 5'd16, 3'd4);
    @(posedge clk);
    #1 drive(4'b0000, 4'b0, 4'b0, 1'b0, 4'd0, 5'd0, 4'd0, 4'd0, 5'd16, 3'd4);
    @(negedge clk);
    check("robfull_rob_valid", 100, 32'(rob_valid), 32'h0);
    check("robfull_in_ready", 100, 32'(in_ready), 32'h0);
    check("robfull_rob_alloc", 100, 32'(rob_alloc), 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    rob_free = 5'd16;
    @(negedge clk);
    check("stall_reset_rob_valid", 101, 32'(rob_valid), 32'h0);
    check("stall_reset_in_ready", 101, 32'(in_ready), 32'h1);
    check("stall_reset_rob_alloc", 101, 32'(rob_alloc), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
